fifo_stream_packetizer: RTL and testbench

//  Drains a show-ahead sync FIFO read port (data valid while !empty, rd_en pops) and emits framed packets on a

---
 rtl/stream_pkt_pkg.sv | 25 ++
 rtl/stream_out_reg.sv | 63 ++++++
 rtl/fifo_stream_packetizer.sv | 130 +++++++++++++
 tb/tb_fifo_stream_packetizer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkt_pkg.sv
// rtl/stream_pkt_pkg.sv - shared types and header packing for the stream packetizer
// Purpose: FSM state encoding, header field offsets and the header pack helper.
// Ports: none (package).
package stream_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_e;

  // Header layout: {seq, len}; the sequence field starts at SEQ_LSB = LEN_WIDTH.
  localparam int LEN_LSB = 0;

  // Packs a header into a 64-bit container; callers size-cast to DATA_WIDTH.
  // len_width is the length field width, which is also the sequence field offset.
  function automatic logic [63:0] pack_header(input logic [63:0] seq,
                                              input logic [63:0] len,
                                              input int          len_width);
    logic [63:0] len_mask;
    len_mask = (64'd1 << len_width) - 64'd1;
    return (seq << (LEN_LSB + len_width)) | ((len & len_mask) << LEN_LSB);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - one-stage valid/ready output register
// Purpose: holds one stream word (data + first + last) until the sink accepts it.
// Ports: clk/rst (sync, active-high); load/in_* from the producer, which may only
//   load while load_ok; m_* stream outputs; m_ready from the sink; load_ok = slot free.
module stream_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  load_ok
);

  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_first_q, m_first_d;
  logic                  m_last_q, m_last_d;

  assign load_ok = !m_valid_q || m_ready;

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_first_d = m_first_q;
    m_last_d  = m_last_q;
    if (load) begin
      m_data_d  = in_data;
      m_valid_d = 1'b1;
      m_first_d = in_first;
      m_last_d  = in_last;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_first_q <= m_first_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_first = m_first_q;
  assign m_last  = m_last_q;

endmodule

// File: rtl/fifo_stream_packetizer.sv
// rtl/fifo_stream_packetizer.sv - frames show-ahead FIFO words into header+payload packets
// Purpose: drains a show-ahead FIFO and emits {seq,len} header then pkt_len payload words.
// Ports: clk/rst (sync, active-high); fifo_dout/fifo_empty/fifo_rd_en FIFO read side;
//   pkt_len sampled at packet start; enable gates new packets; m_data/m_valid/m_ready/
//   m_first/m_last output stream; busy = packet in progress or word pending;
//   pkt_count = completed packets, wrapping.
module fifo_stream_packetizer
  import stream_pkt_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 16,
  localparam int SEQ_WIDTH  = DATA_WIDTH - LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy,
  output logic [SEQ_WIDTH-1:0]  pkt_count
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [SEQ_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic                  load;
  logic                  load_ok;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_first;
  logic                  load_last;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    seq_d       = seq_q;
    pkt_count_d = pkt_count_q;
    load        = 1'b0;
    load_data   = '0;
    load_first  = 1'b0;
    load_last   = 1'b0;
    fifo_rd_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = HEADER;
          len_d   = pkt_len;
        end
      end
      HEADER: begin
        if (load_ok) begin
          load       = 1'b1;
          load_data  = DATA_WIDTH'(pack_header(64'(seq_q), 64'(len_q), LEN_WIDTH));
          load_first = 1'b1;
          load_last  = (len_q == '0);
          seq_d      = seq_q + 1'b1;
          rem_d      = len_q;
          state_d    = (len_q == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Pop only when the output slot can take the word; gating with rst keeps
        // the FIFO untouched during the reset cycle.
        fifo_rd_en = !fifo_empty && load_ok && !rst;
        if (fifo_rd_en) begin
          load      = 1'b1;
          load_data = fifo_dout;
          load_last = (rem_q == LEN_WIDTH'(1));
          rem_d     = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (m_valid && m_ready && m_last) begin
      pkt_count_d = pkt_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      seq_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      seq_q       <= seq_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .in_data (load_data),
    .in_first(load_first),
    .in_last (load_last),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_first (m_first),
    .m_last  (m_last),
    .load_ok (load_ok)
  );

  assign busy      = (state_q != IDLE) || m_valid;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_stream_packetizer.sv
// tb/tb_fifo_stream_packetizer.sv - self-checking bench for fifo_stream_packetizer
module tb_fifo_stream_packetizer;

  localparam int DW = 24;
  localparam int LW = 16;
  localparam int SW = DW - LW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [LW-1:0] pkt_len;
  logic          enable;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_first;
  logic          m_last;
  logic          busy;
  logic [SW-1:0] pkt_count;

  always #5 clk = ~clk;

  fifo_stream_packetizer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .pkt_len   (pkt_len),
    .enable    (enable),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_first   (m_first),
    .m_last    (m_last),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW+1:0] exp_q[$];
  int            seq_m = 0;
  int            pkts_m = 0;
  int            pops = 0;
  int            acc_cnt = 0;
  int            ready_mode = 0;
  logic          stall_prev = 1'b0;
  logic [DW+1:0] prev_word;
  logic          rd_c, acc_c;
  logic [DW+1:0] word_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push_fifo(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    update_fifo();
  endtask

  task automatic add_hdr(input int len);
    exp_q.push_back({1'b1, (len == 0), 8'(seq_m), 16'(len)});
    seq_m = (seq_m + 1) % 256;
    pkts_m++;
  endtask

  task automatic add_word(input logic [DW-1:0] w, input logic last);
    exp_q.push_back({1'b0, last, w});
  endtask

  task automatic new_pkt(input int len);
    logic [DW-1:0] w;
    add_hdr(len);
    for (int i = 0; i < len; i++) begin
      w = DW'($urandom);
      push_fifo(w);
      add_word(w, i == len - 1);
    end
  endtask

  // One clock: sample at the falling edge, then apply pops/acceptances after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      if (stall_prev) begin
        chk("stall_hold", {m_valid, m_first, m_last, m_data}, {1'b1, prev_word});
      end
    end
    rd_c       = fifo_rd_en;
    acc_c      = m_valid & m_ready;
    word_c     = {m_first, m_last, m_data};
    prev_word  = word_c;
    stall_prev = m_valid & !m_ready & !rst;
    @(posedge clk);
    #1;
    if (rd_c) begin
      if (fifo_q.size() == 0) chk("pop_of_empty", 1, 0);
      else begin
        void'(fifo_q.pop_front());
        pops++;
      end
    end
    if (acc_c && !rst) begin
      acc_cnt++;
      if (exp_q.size() == 0) chk("extra_word", word_c, 0);
      else chk("stream_word", word_c, exp_q.pop_front());
    end
    update_fifo();
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_done", (exp_q.size() != 0) || busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_first"}, m_first, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pkt_count"}, pkt_count, 0);
  endtask

  initial begin
    logic [DW-1:0] t2w, w1, w2, w;
    int p0, n, base, rem, l6;

    rst = 1'b1; enable = 1'b0; pkt_len = '0; m_ready = 1'b1;
    update_fifo();
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // 1: four-word packet, continuous ready
    pkt_len = 16'd4;
    p0 = pops;
    new_pkt(4);
    enable = 1'b1;
    tick();
    tick();
    chk("t1_hdr_valid_first", {m_valid, m_first}, 2'b11);
    chk("t1_busy", busy, 1);
    drain(200);
    enable = 1'b0;
    chk("t1_pops", pops - p0, 4);
    chk("t1_pkt_count", pkt_count, pkts_m % 256);

    // 2: header-only packet, FIFO word must stay
    pkt_len = '0;
    t2w = DW'($urandom);
    push_fifo(t2w);
    add_hdr(0);
    p0 = pops;
    enable = 1'b1;
    n = 0;
    while (!(m_valid && m_first) && n < 20) begin
      tick();
      n++;
    end
    enable = 1'b0;
    chk("t2_first_last", {m_valid, m_first, m_last}, 3'b111);
    drain(50);
    chk("t2_no_pop", pops - p0, 0);
    chk("t2_fifo_kept", fifo_q.size(), 1);
    chk("t2_pkt_count", pkt_count, pkts_m % 256);

    // 3: FIFO words trickle in; packetizer stalls without popping empty
    pkt_len = 16'd3;
    w1 = DW'($urandom);
    w2 = DW'($urandom);
    add_hdr(3);
    add_word(t2w, 1'b0);
    add_word(w1, 1'b0);
    add_word(w2, 1'b1);
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 5) begin
        chk("t3_stall_valid", m_valid, 0);
        chk("t3_stall_busy", busy, 1);
        chk("t3_stall_rd_en", fifo_rd_en, 0);
        push_fifo(w1);
      end
      if (c == 9) push_fifo(w2);
      tick();
    end
    drain(100);
    enable = 1'b0;
    chk("t3_pkt_count", pkt_count, pkts_m % 256);

    // 4: toggling ready, pkt_len scrambled mid-packet
    pkt_len = 16'd8;
    ready_mode = 1;
    new_pkt(8);
    enable = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      pkt_len = LW'($urandom);
      tick();
    end
    drain(200);
    enable = 1'b0;
    ready_mode = 0;
    m_ready = 1'b1;
    chk("t4_pkt_count", pkt_count, pkts_m % 256);

    // 5: reset after header + 2 payload words
    pkt_len = 16'd4;
    new_pkt(4);
    enable = 1'b1;
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_accepted_before_rst", acc_cnt - base, 3);
    rst = 1'b1;
    ready_mode = 3;
    m_ready = 1'b0;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    m_ready = 1'b1;
    ready_mode = 0;
    chk_reset_outputs("t5_rst");
    exp_q.delete();
    seq_m = 0;
    pkts_m = 0;
    if (fifo_q.size() == 0) begin
      w = DW'($urandom);
      push_fifo(w);
    end
    rem = fifo_q.size();
    pkt_len = LW'(rem);
    add_hdr(rem);
    for (int i = 0; i < rem; i++) add_word(fifo_q[i], i == rem - 1);
    enable = 1'b1;
    drain(100);
    enable = 1'b0;
    chk("t5_fifo_drained", fifo_q.size(), 0);
    chk("t5_pkt_count", pkt_count, pkts_m % 256);

    // 6: 256 back-to-back packets, random ready; seq and pkt_count wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    seq_m = 0;
    pkts_m = 0;
    l6 = $urandom_range(1, 3);
    pkt_len = LW'(l6);
    p0 = pops;
    for (int k = 0; k < 256; k++) new_pkt(l6);
    ready_mode = 2;
    enable = 1'b1;
    drain(20000);
    chk("t6_pops", pops - p0, 256 * l6);
    chk("t6_pkt_count_wrap", pkt_count, pkts_m % 256);
    new_pkt(l6);
    drain(200);
    enable = 1'b0;
    chk("t6_pkt_count_after", pkt_count, pkts_m % 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
